data_mem_bus: RTL and testbench
===============================

Name: data_mem_bus

Overview:
- Parametrised successor to the single-cycle word data memory.
- Byte-addressed, little-endian data RAM for the RISC-V load/store path, with a valid/ready request port and a one-shot response port.
- Adds RV32I access sizes (byte/half/word) with sign/zero extension, byte-lane writes, misalignment/illegal-size error reporting, and programmable wait states.
- Sits between the core's memory stage and the data RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, ≥4.
- WAIT_STATES, 0, extra cycles between accept and response; 0..15.
- INIT_FILE, "", if non-empty, array is preloaded with $readmemh at elaboration.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, LSB-aligned (SB uses [7:0], SH uses [15:0]).
- resp_valid  output  1  one-cycle pulse, response fields valid.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal access.

Behaviour:
- **Clock and reset:** one clock (clk); rst is synchronous and active-high.
- **Reset values:** state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are not cleared by reset.
- **Addressing:**
  - AW = log2(DEPTH_WORDS); word index = req_addr[AW+1:2]; lane = req_addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- **Error checks:**
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Illegal: funct3 ∈ {011, 110, 111}; also stores with funct3 100/101.
  - Either condition sets err: no array write, rdata=0.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - req_ready=1.
  - On an accept (req_valid & req_ready) at edge N:
    - Capture funct3, lane and err.
    - If a store without err, write the enabled byte lanes at edge N: SB writes lane addr[1:0], SH writes lanes {addr[1],0} and {addr[1],1}, SW writes all four lanes; other lanes unchanged.
    - If a load, read the addressed word at edge N.
    - Go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1), else go to RESP.
- **WAIT:**
  - req_ready=0.
  - Counter decrements each cycle; go to RESP when it is 0.
- **RESP:**
  - req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata/resp_err hold their values until the next response; they are cleared only by reset.
- **Latency and throughput:** accept at edge N gives resp_valid high in the cycle after edge N+1+WAIT_STATES. Throughput is one access per 2+WAIT_STATES cycles.
- **Load extraction:**
  - B/BU select byte lane addr[1:0]; B sign-extends bit 7, BU zero-extends.
  - H/HU select half addr[1]; H sign-extends bit 15, HU zero-extends.
  - W returns the full word.
- **Ordering:** the store write happens at the accept edge, so the next request always sees it (read-after-write coherent).
- **Idle inputs:** req_* ignored while req_ready=0; a req_valid held high is accepted on the first IDLE cycle.
- **Reset mid-operation:** return to IDLE, drop the pending response and clear the outputs. A store already accepted stays committed.
- **Simultaneous rst and req_valid:** reset wins, the request is not accepted and no write occurs.

Test Plan:
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → each resp_valid one cycle, 2 cycles after accept; rdata=0xDEADBEEF, err=0.
- SB 0x7F @0x11, SH 0x8001 @0x12, then LW @0x10 → 0x80017FEF. Then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LH @0x12 → 0xFFFF8001; LHU @0x12 → 0x00008001.
- Misaligned LW @0x11, SH @0x13, and funct3=011 → err=1, rdata=0. A following LW @0x10 is unchanged (0x80017FEF).
- DEPTH_WORDS=256: SW 0x12345678 @0x400 → LW @0x000 reads 0x12345678 (wrap).
- WAIT_STATES=3: back-to-back req_valid held high → req_ready low for 4 cycles after each accept; resp_valid spaced 5 cycles apart.
- Assert rst in WAIT after accepting SW 0xA5A5A5A5 @0x20 → no resp_valid, IDLE next cycle; LW @0x20 returns 0xA5A5A5A5. rst and req_valid in the same cycle → no write, no response.

Source files
------------

// File: rtl/data_mem_bus.sv
// Byte-addressed little-endian data RAM for the load/store path: RV32I sized accesses,
// valid/ready request port, one-shot response, programmable wait states.
module data_mem_bus #(
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d, wr_q, wr_d;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d, rd_word_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          accept, misaligned, illegal, req_err, mem_we;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic          unused_addr;

  // Upper address bits are deliberately dropped so the array aliases modulo its size.
  assign idx         = req_addr[AW+1:2];
  assign lane        = req_addr[1:0];
  assign unused_addr = ^req_addr[31:AW+2];

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign misaligned = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((req_funct3 == 3'b010) && (lane != 2'b00));
  assign illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_write && req_funct3[2]);
  assign req_err    = misaligned || illegal;
  assign mem_we     = accept && req_write && !req_err;

  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Store commits and load read both happen on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      rd_word_q <= mem_q[idx];
      for (int b = 0; b < 4; b++)
        if (mem_we && byte_en[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
    err_d        = err_q;
    wr_d         = wr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        f3_d    = req_funct3;
        lane_d  = lane;
        err_d   = req_err;
        wr_d    = req_write;
        cnt_d   = CNT_INIT;
        state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (err_q || wr_q) ? 32'd0 : load_ext(rd_word_q, f3_q, lane_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      f3_q         <= 3'd0;
      lane_q       <= 2'd0;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_bus.sv
// Directed bench for data_mem_bus: a zero-wait instance driven from a vector table and a
// three-wait instance exercised with hand-written throughput and reset sequences.
module tb_data_mem_bus;
  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v3, rdy0, rdy3, rv0, rv3, err0, err3;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rd0, rd3;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  data_mem_bus #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_write(wr),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0));

  data_mem_bus #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_write(wr),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3));

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the chosen instance; lat counts negedges after the accept edge.
  task automatic xact(input bit sel3, input logic w, input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic e, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    wr = w; f3 = fn; addr = a; wdata = d;
    if (sel3) v3 = 1'b1; else v0 = 1'b1;
    while (!(sel3 ? rdy3 : rdy0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    v0 = 1'b0; v3 = 1'b0;
    lat = 0;
    while (!(sel3 ? rv3 : rv0) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = sel3 ? rd3 : rd0;
    e     = sel3 ? err3 : err0;
    @(negedge clk);
    check("pulse width", sel3 ? rv3 : rv0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    vt[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 3'b000, 32'h011, 32'h1234567F, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 3'b001, 32'h012, 32'hBEEF8001, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'h80017FEF, 1'b0};
    vt[5]  = '{1'b0, 3'b000, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[6]  = '{1'b0, 3'b100, 32'h013, 32'h0,        32'h00000080, 1'b0};
    vt[7]  = '{1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFF8001, 1'b0};
    vt[8]  = '{1'b0, 3'b101, 32'h012, 32'h0,        32'h00008001, 1'b0};
    vt[9]  = '{1'b0, 3'b010, 32'h011, 32'h0,        32'h0,        1'b1};
    vt[10] = '{1'b1, 3'b001, 32'h013, 32'h0000FFFF, 32'h0,        1'b1};
    vt[11] = '{1'b0, 3'b011, 32'h010, 32'h0,        32'h0,        1'b1};
    vt[12] = '{1'b1, 3'b100, 32'h010, 32'h000000AA, 32'h0,        1'b1};
    vt[13] = '{1'b0, 3'b010, 32'h010, 32'h0,        32'h80017FEF, 1'b0};
    vt[14] = '{1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0,        1'b0};
    vt[15] = '{1'b0, 3'b010, 32'h000, 32'h0,        32'h12345678, 1'b0};
    vt[16] = '{1'b0, 3'b000, 32'h011, 32'h0,        32'h0000007F, 1'b0};
    vt[17] = '{1'b0, 3'b001, 32'h010, 32'h0,        32'h00007FEF, 1'b0};
    vt[18] = '{1'b1, 3'b010, 32'h7FC, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[19] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[20] = '{1'b0, 3'b001, 32'h3FE, 32'h0,        32'hFFFFCAFE, 1'b0};
    vt[21] = '{1'b0, 3'b110, 32'h3FC, 32'h0,        32'h0,        1'b1};
    vt[22] = '{1'b0, 3'b101, 32'h3FD, 32'h0,        32'h0,        1'b1};

    rst = 1'b1; v0 = 1'b0; v3 = 1'b0;
    wr = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset ready0", rdy0, 32'd1);
    check("reset valid0", rv0, 32'd0);
    check("reset rdata0", rd0, 32'd0);
    check("reset err0", err0, 32'd0);
    check("reset ready3", rdy3, 32'd1);
    check("reset valid3", rv3, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      xact(1'b0, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wdata, rd, e, lat);
      check($sformatf("vec%0d rdata", i), rd, vt[i].rdata);
      check($sformatf("vec%0d err", i), e, vt[i].err);
      check($sformatf("vec%0d latency", i), lat, 32'd1);
    end

    // Valid held high on the 3-wait instance: accepts every 5 cycles.
    @(negedge clk);
    wr = 1'b1; f3 = 3'b010; addr = 32'h40; wdata = 32'h11111111; v3 = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("bb ready t%0d", i), rdy3, (i % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("bb resp_valid t%0d", i), rv3,
            (i % 5 == 0 && i > 0) ? 32'd1 : 32'd0);
    end
    v3 = 1'b0;

    xact(1'b1, 1'b1, 3'b010, 32'h24, 32'h5A5A5A5A, rd, e, lat);
    check("ws3 store latency", lat, 32'd4);
    xact(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, rd, e, lat);
    check("ws3 load rdata", rd, 32'h5A5A5A5A);
    check("ws3 load latency", lat, 32'd4);

    // Reset while waiting: response dropped, outputs cleared, store stays committed.
    @(negedge clk);
    wr = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'hA5A5A5A5; v3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0;
    check("mid ready in wait", rdy3, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid ready after rst", rdy3, 32'd1);
    check("mid rdata cleared", rd3, 32'd0);
    check("mid err cleared", err3, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("mid no resp", rv3, 32'd0);
      @(negedge clk);
    end
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    check("mid committed rdata", rd, 32'hA5A5A5A5);
    check("mid committed err", e, 32'd0);

    // Request coincident with reset is dropped.
    @(negedge clk);
    rst = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'hFFFFFFFF; v3 = 1'b1;
    @(negedge clk);
    rst = 1'b0; v3 = 1'b0;
    check("simul ready", rdy3, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("simul no resp", rv3, 32'd0);
      @(negedge clk);
    end
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    check("simul no write", rd, 32'hA5A5A5A5);
    check("simul latency", lat, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
